isram_arbiter: RTL and testbench

Port controller for the byte-write / word-read instruction SRAM. It owns the SRAM's single address port and shares it between two requesters: a program loader that streams bytes in, and the core fetch unit that reads 32-bit instruction words. It sequences boot (load-only) and run (shared, round-robin) phases and registers fetched words.

---
 rtl/isram_arbiter_pkg.sv | 16 +
 rtl/isram_arbiter_if.sv | 41 ++++
 rtl/isram_rr_arb.sv | 35 +++
 rtl/isram_arbiter.sv | 75 +++++++
 tb/tb_isram_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/isram_arbiter_pkg.sv
// Shared definitions for the instruction-SRAM port controller: phase encoding
// and instruction-word geometry.
package isram_arbiter_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int INST_BYTES = 4;

  function automatic int inst_w(input int n);
    return INST_BYTES * n;
  endfunction

endpackage

// File: rtl/isram_arbiter_if.sv
// Loader, fetch and SRAM-port signals of the instruction-SRAM controller.
// The controller uses the slave view; the surrounding system uses the master view.
interface isram_arbiter_if #(
  parameter int M = 10,
  parameter int N = 8
);
  import isram_arbiter_pkg::*;

  localparam int IW = inst_w(N);

  logic          ld_valid;
  logic          ld_ready;
  logic [M-1:0]  ld_addr;
  logic [N-1:0]  ld_data;
  logic          ld_last;
  logic          fetch_req;
  logic [M-1:0]  fetch_addr;
  logic          fetch_gnt;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic          fetch_err;
  logic          booted;
  logic [M:0]    ld_count;
  logic          sram_w_en;
  logic [M-1:0]  sram_addr;
  logic [N-1:0]  sram_data;
  logic [IW-1:0] sram_inst;

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr, sram_inst,
    output ld_ready, fetch_gnt, inst_valid, inst, fetch_err, booted, ld_count,
           sram_w_en, sram_addr, sram_data
  );

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, fetch_req, fetch_addr, sram_inst,
    input  ld_ready, fetch_gnt, inst_valid, inst, fetch_err, booted, ld_count,
           sram_w_en, sram_addr, sram_data
  );

endinterface

// File: rtl/isram_rr_arb.sv
// Two-requester round-robin grant. A lone requester always wins; on a conflict
// the side that did not win last time gets the grant.
module isram_rr_arb
  import isram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // High when requester b (fetch) won the most recent arbitration.
  logic last_b;

  always_comb begin
    gnt_a = req_a;
    gnt_b = req_b;
    if (req_a && req_b) begin
      gnt_a = last_b;
      gnt_b = ~last_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (en && (gnt_a || gnt_b)) begin
      last_b <= gnt_b;
    end
  end

endmodule

// File: rtl/isram_arbiter.sv
// Instruction-SRAM port controller: load-only boot phase, then round-robin
// sharing of the single SRAM port between the byte loader and word fetch.
module isram_arbiter
  import isram_arbiter_pkg::*;
#(
  parameter int M = 10,
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            rst,
  isram_arbiter_if.slave  bus
);

  localparam logic [M-1:0] LAST_WORD = {{(M-2){1'b1}}, 2'b00};
  localparam logic [M:0]   LD_MAX    = {1'b1, {M{1'b0}}};

  state_t state;
  logic   run;
  logic   gnt_ld;
  logic   gnt_fe;
  logic   ld_acc;
  logic   fe_acc;
  logic   addr_err;

  assign run = (state == RUN);

  isram_rr_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .req_a (bus.ld_valid),
    .req_b (bus.fetch_req),
    .gnt_a (gnt_ld),
    .gnt_b (gnt_fe)
  );

  // During boot the loader owns the port outright and fetch is locked out.
  assign bus.ld_ready  = run ? gnt_ld : 1'b1;
  assign bus.fetch_gnt = run & gnt_fe;

  assign ld_acc = bus.ld_valid & bus.ld_ready;
  assign fe_acc = bus.fetch_gnt;

  assign bus.sram_w_en = ld_acc;
  assign bus.sram_addr = ld_acc ? bus.ld_addr : bus.fetch_addr;
  assign bus.sram_data = bus.ld_data;

  // A word must be 4-byte aligned and fit without wrapping past the top.
  assign addr_err = (bus.fetch_addr[1:0] != 2'b00) || (bus.fetch_addr > LAST_WORD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= BOOT;
      bus.booted     <= 1'b0;
      bus.inst_valid <= 1'b0;
      bus.fetch_err  <= 1'b0;
      bus.inst       <= '0;
      bus.ld_count   <= '0;
    end else begin
      if ((state == BOOT) && ld_acc && bus.ld_last) begin
        state      <= RUN;
        bus.booted <= 1'b1;
      end
      if (ld_acc && (bus.ld_count != LD_MAX)) begin
        bus.ld_count <= bus.ld_count + (M+1)'(1);
      end
      bus.inst_valid <= fe_acc;
      bus.fetch_err  <= fe_acc & addr_err;
      if (fe_acc) begin
        bus.inst <= bus.sram_inst;
      end
    end
  end

endmodule

// File: tb/tb_isram_arbiter.sv
// Bench for isram_arbiter: directed stimulus, with fetch responses checked by
// a scoreboard monitor against hand-computed words.
module tb_isram_arbiter;
  import isram_arbiter_pkg::*;

  localparam int M  = 10;
  localparam int N  = 8;
  localparam int IW = 4 * N;

  typedef struct {
    logic [IW-1:0] inst;
    logic [IW-1:0] mask;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  isram_arbiter_if #(.M(M), .N(N)) bus ();

  isram_arbiter #(.M(M), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM model: byte writes, combinational big-endian word read.
  logic [N-1:0] mem [0:(2**M)-1];
  wire  [M-1:0] a0 = bus.sram_addr;
  wire  [M-1:0] a1 = a0 + M'(1);
  wire  [M-1:0] a2 = a0 + M'(2);
  wire  [M-1:0] a3 = a0 + M'(3);

  always @(posedge clk) begin
    if (bus.sram_w_en) mem[bus.sram_addr] <= bus.sram_data;
  end
  assign bus.sram_inst = {mem[a0], mem[a1], mem[a2], mem[a3]};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
  endtask

  // Scoreboard monitor: every inst_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.inst_valid) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_inst_valid got inst=0x%0h expected no response", bus.inst);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("inst_word", 64'(bus.inst & e.mask), 64'(e.inst & e.mask));
        chk("fetch_err", 64'(bus.fetch_err), 64'(e.err));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.ld_last    = 1'b0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
  endtask

  task automatic push(input logic [IW-1:0] inst, input logic [IW-1:0] mask, input logic err);
    exp_t e;
    e.inst = inst;
    e.mask = mask;
    e.err  = err;
    sbq.push_back(e);
  endtask

  // One granted fetch; the response is left to the monitor.
  task automatic fetch(input logic [M-1:0] addr, input logic [IW-1:0] inst,
                       input logic [IW-1:0] mask, input logic err);
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = addr;
    @(negedge clk);
    chk("fetch_gnt", 64'(bus.fetch_gnt), 64'd1);
    chk("fetch_sram_w_en", 64'(bus.sram_w_en), 64'd0);
    push(inst, mask, err);
    cyc();
  endtask

  task automatic load(input logic [M-1:0] addr, input logic [N-1:0] data, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    bus.ld_last  = last;
    @(negedge clk);
    chk("ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("ld_sram_w_en", 64'(bus.sram_w_en), 64'd1);
    chk("ld_sram_addr", 64'(bus.sram_addr), 64'(addr));
    chk("ld_sram_data", 64'(bus.sram_data), 64'(data));
    cyc();
  endtask

  task automatic chk_reset_vals();
    chk("rst_booted", 64'(bus.booted), 64'd0);
    chk("rst_ld_count", 64'(bus.ld_count), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_fetch_err", 64'(bus.fetch_err), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_ld_ready", 64'(bus.ld_ready), 64'd1);
    chk("rst_fetch_gnt", 64'(bus.fetch_gnt), 64'd0);
  endtask

  initial begin
    logic [N-1:0] boot_img [0:3];
    boot_img[0] = 8'h13;
    boot_img[1] = 8'h00;
    boot_img[2] = 8'h00;
    boot_img[3] = 8'h00;

    idle();
    rst = 1'b1;
    cyc();
    chk_reset_vals();
    rst = 1'b0;

    // Fetch is locked out during boot.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("boot_fetch_gnt", 64'(bus.fetch_gnt), 64'd0);
      chk("boot_inst_valid", 64'(bus.inst_valid), 64'd0);
      cyc();
    end
    idle();

    // Boot image, last byte flagged.
    for (int i = 0; i < 4; i++) load(M'(i), boot_img[i], (i == 3));
    idle();
    chk("booted", 64'(bus.booted), 64'd1);
    chk("ld_count_boot", 64'(bus.ld_count), 64'd4);

    fetch(M'(0), 32'h1300_0000, 32'hFFFF_FFFF, 1'b0);
    idle();
    cyc();

    // Contention: loader wins first, then strict alternation.
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = M'(10'h100);
    bus.ld_data    = 8'h55;
    bus.ld_last    = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_ld_ready", 64'(bus.ld_ready), 64'((k % 2) == 0));
      chk("rr_fetch_gnt", 64'(bus.fetch_gnt), 64'((k % 2) == 1));
      if ((k % 2) == 1) push(32'h1300_0000, 32'hFFFF_FFFF, 1'b0);
      cyc();
    end
    idle();
    chk("ld_count_rr", 64'(bus.ld_count), 64'd7);
    chk("booted_after_rr", 64'(bus.booted), 64'd1);

    // Back-to-back fetches with misaligned / wrapping addresses.
    fetch(M'(10'h002), '0, '0, 1'b1);
    fetch(M'(10'h3FD), '0, '0, 1'b1);
    fetch(M'(10'h3FC), '0, '0, 1'b0);
    idle();
    cyc();

    // Read-after-write in RUN.
    load(M'(8), 8'hAB, 1'b0);
    idle();
    fetch(M'(8), 32'hAB00_0000, 32'hFF00_0000, 1'b0);
    idle();
    chk("ld_count_raw", 64'(bus.ld_count), 64'd8);
    cyc();
    cyc();

    // Asynchronous reset while a response is being presented.
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = '0;
    @(negedge clk);
    chk("pre_rst_gnt", 64'(bus.fetch_gnt), 64'd1);
    cyc();
    chk("pre_rst_inst_valid", 64'(bus.inst_valid), 64'd1);
    chk("pre_rst_inst", 64'(bus.inst), 64'h1300_0000);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals();
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_fetch_gnt", 64'(bus.fetch_gnt), 64'd0);
    cyc();
    idle();

    // Single-byte boot image, then the SRAM must still hold earlier data.
    load(M'(10'h200), 8'h77, 1'b1);
    idle();
    chk("reboot_booted", 64'(bus.booted), 64'd1);
    chk("reboot_ld_count", 64'(bus.ld_count), 64'd1);
    fetch(M'(8), 32'hAB00_0000, 32'hFF00_0000, 1'b0);
    fetch(M'(0), 32'h1300_0000, 32'hFFFF_FFFF, 1'b0);
    idle();
    cyc();
    cyc();

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
